gold_phase_sched: RTL and testbench
===================================

GOLD_PHASE_SCHED -- requirements
Module: gold_phase_sched

Interface
REQ-001 Parameter LENGTH, default 63, Gold code period in chips.
REQ-002 Parameter POLY_LEN, default $clog2(LENGTH) = 6, shift/phase word width.
REQ-003 Parameter N_REQ, default 4, number of phase requesters.
REQ-004 Port clkin  input  1  single clock; all logic on rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port req_valid  input  N_REQ  per-requester phase request.
REQ-007 Port req_shift  input  N_REQ*POLY_LEN  requested shift; requester i at bits [i*POLY_LEN +: POLY_LEN].
REQ-008 Port req_ready  output  N_REQ  one-hot accept; transfer when req_valid[i] and req_ready[i] are both high at a clkin edge.
REQ-009 Port m_axis_tvalid  output  1  phase-load valid toward the Gold generator.
REQ-010 Port m_axis_tdata  output  POLY_LEN  shift value toward the Gold generator.
REQ-011 Port m_axis_tready  input  1  generator ready.
REQ-012 Port strobe_i  input  1  one-cycle pulse per emitted chip, from the generator.
REQ-013 Port busy_o  output  1  high in LOAD, RUN and DONE.
REQ-014 Port active_id_o  output  $clog2(N_REQ)  index of the requester currently owning the generator.
REQ-015 Port period_done_o  output  1  one-cycle pulse at end of a full code period.
REQ-016 Port err_o  output  1  one-cycle pulse on rejected out-of-range shift.

Function
REQ-017 FSM states IDLE, LOAD, RUN, DONE; encoding is free.
REQ-018 IDLE: round-robin grant among asserted req_valid, search starting at pointer rr_ptr and wrapping; req_ready asserted combinationally for the winner only, and only in IDLE.
REQ-019 Accepted shift < LENGTH: latch shift and winner id, set rr_ptr = winner+1 mod N_REQ, go to LOAD next cycle.
REQ-020 Accepted shift >= LENGTH (e.g. 63): request consumed, err_o pulses high the following cycle, rr_ptr advances, FSM stays IDLE, generator untouched.
REQ-021 LOAD: m_axis_tvalid = 1, m_axis_tdata = latched shift, both stable until the edge with m_axis_tready = 1; then RUN with chip counter cleared.
REQ-022 RUN: count strobe_i pulses; on the LENGTH-th pulse go to DONE; strobes outside RUN are ignored.
REQ-023 DONE: period_done_o = 1 for exactly one cycle, then IDLE; a new grant is possible in the first IDLE cycle.
REQ-024 Latency: accept edge -> tvalid high 1 cycle later; last strobe edge -> period_done_o high 1 cycle later.
REQ-025 m_axis_tvalid never deasserts before a handshake; tdata is 0 whenever tvalid is 0.
REQ-026 Requests arriving while busy_o = 1 receive no req_ready and are held by the requester (no internal queue).
REQ-027 Chip counter is $clog2(LENGTH+1) bits wide and saturates at LENGTH, never wraps.
REQ-028 active_id_o holds the last winner until the next accepted request.

Reset
REQ-029 While rst = 1, regardless of clock: FSM = IDLE, rr_ptr = 0, counter = 0; req_ready, m_axis_tvalid, m_axis_tdata, busy_o, active_id_o, period_done_o, err_o are all 0.
REQ-030 Reset asserted during LOAD or RUN aborts the operation and drops tvalid immediately; no period_done_o is produced for the aborted operation.
REQ-031 After rst deasserts, the first clkin edge may already grant a request.

Verification
REQ-032 Single request: req_valid[2] = 1, shift = 5, tready = 1 -> req_ready[2] for 1 cycle, tvalid with tdata = 5 for 1 cycle, period_done_o after the 63rd strobe, active_id_o = 2.
REQ-033 Round-robin: all four requesters valid continuously -> grants in order 0,1,2,3,0, with each grant following the previous period_done_o.
REQ-034 Backpressure: tready held low for 10 cycles in LOAD -> tvalid and tdata stable for 10 cycles, handshake on the first tready = 1 cycle.
REQ-035 Out of range: requester 1 shift = 63 -> req_ready[1] pulse, err_o pulse next cycle, tvalid stays 0, next grant goes to requester 2.
REQ-036 Reset mid-RUN after 30 strobes -> all outputs 0 asynchronously, no period_done_o; a fresh request then completes normally with 63 strobes.
REQ-037 Strobe while IDLE or LOAD -> chip counter unchanged; RUN still requires a full 63 strobes.

Source files
------------

// File: rtl/gold_phase_sched.sv
// Round-robin phase-load scheduler in front of a Gold code generator: grants one
// requester at a time, loads its shift over a valid/ready link and waits one full period.
module gold_phase_sched #(
  parameter int LENGTH   = 63,
  parameter int POLY_LEN = $clog2(LENGTH),
  parameter int N_REQ    = 4
) (
  input  logic                          clkin,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*POLY_LEN-1:0]     req_shift,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          m_axis_tvalid,
  output logic [POLY_LEN-1:0]           m_axis_tdata,
  input  logic                          m_axis_tready,
  input  logic                          strobe_i,
  output logic                          busy_o,
  output logic [$clog2(N_REQ)-1:0]      active_id_o,
  output logic                          period_done_o,
  output logic                          err_o
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(LENGTH + 1);
  localparam logic [POLY_LEN:0]  LEN_EXT  = (POLY_LEN + 1)'(LENGTH);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(LENGTH);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(LENGTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_active_id;
  logic [POLY_LEN-1:0] r_shift;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_err;

  logic                w_gnt_any;
  logic [ID_W-1:0]     w_gnt_id;
  logic [POLY_LEN-1:0] w_sel_shift;
  logic                w_in_range;
  logic                w_take;

  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int ofs);
    int sum;
    sum = int'(base) + ofs;
    return ID_W'(sum % N_REQ);
  endfunction

  // Walk from the highest offset down so the closest valid requester to r_rr_ptr wins.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[rr_index(r_rr_ptr, k)]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = rr_index(r_rr_ptr, k);
      end
    end
  end

  assign w_sel_shift = req_shift[int'(w_gnt_id)*POLY_LEN +: POLY_LEN];
  assign w_in_range  = ({1'b0, w_sel_shift} < LEN_EXT);
  assign w_take      = (r_state == S_IDLE) && w_gnt_any;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    req_ready     = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    busy_o        = 1'b1;
    period_done_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (w_gnt_any && !rst) begin
          req_ready[w_gnt_id] = 1'b1;
          if (w_in_range) begin
            w_next = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = r_shift;
        if (m_axis_tready) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (strobe_i && (r_cnt == CNT_LAST)) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        period_done_o = 1'b1;
        w_next        = S_IDLE;
      end
      default: begin
        busy_o = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  // A rejected shift still consumes the request and moves the pointer on.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_active_id <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_take) begin
        r_rr_ptr <= rr_index(w_gnt_id, 1);
        if (w_in_range) begin
          r_active_id <= w_gnt_id;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (w_take && w_in_range) begin
      r_shift <= w_sel_shift;
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if ((r_state == S_LOAD) && m_axis_tready) begin
      r_cnt <= '0;
    end else if ((r_state == S_RUN) && strobe_i && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign active_id_o = r_active_id;
  assign err_o       = r_err;

endmodule

// File: tb/tb_gold_phase_sched.sv
// Directed bench for gold_phase_sched: reset, round-robin order, single request,
// backpressure, out-of-range rejection, reset mid-run.
module tb_gold_phase_sched;

  localparam int LENGTH   = 63;
  localparam int POLY_LEN = 6;
  localparam int N_REQ    = 4;

  logic                      clkin;
  logic                      rst;
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ*POLY_LEN-1:0] req_shift;
  logic [N_REQ-1:0]          req_ready;
  logic                      m_axis_tvalid;
  logic [POLY_LEN-1:0]       m_axis_tdata;
  logic                      m_axis_tready;
  logic                      strobe_i;
  logic                      busy_o;
  logic [1:0]                active_id_o;
  logic                      period_done_o;
  logic                      err_o;

  int n_checks = 0;
  int n_fail   = 0;

  gold_phase_sched #(
    .LENGTH  (LENGTH),
    .POLY_LEN(POLY_LEN),
    .N_REQ   (N_REQ)
  ) dut (
    .clkin        (clkin),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_shift    (req_shift),
    .req_ready    (req_ready),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tready(m_axis_tready),
    .strobe_i     (strobe_i),
    .busy_o       (busy_o),
    .active_id_o  (active_id_o),
    .period_done_o(period_done_o),
    .err_o        (err_o)
  );

  initial begin
    clkin = 1'b0;
    forever #5 clkin = ~clkin;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic set_shift(input int lane, input int val);
    req_shift[lane*POLY_LEN +: POLY_LEN] = POLY_LEN'(val);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    check({tag, "_tdata"}, 32'(m_axis_tdata), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_id"}, 32'(active_id_o), 32'd0);
    check({tag, "_done"}, 32'(period_done_o), 32'd0);
    check({tag, "_err"}, 32'(err_o), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    req_valid     = '0;
    req_shift     = '0;
    m_axis_tready = 1'b0;
    strobe_i      = 1'b0;
    #1;
    req_valid = 4'hF;
    #1;
    check_all_zero("reset");
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("post_reset_busy", 32'(busy_o), 32'd0);

    // Round-robin with every requester valid: 0,1,2,3,0
    for (int i = 0; i < N_REQ; i++) set_shift(i, 10 + i);
    m_axis_tready = 1'b1;
    req_valid     = 4'hF;
    #1;
    for (int g = 0; g < 5; g++) begin
      check("rr_ready", 32'(req_ready), 32'(1 << (g % 4)));
      tick();
      check("rr_tvalid", 32'(m_axis_tvalid), 32'd1);
      check("rr_tdata", 32'(m_axis_tdata), 32'(10 + (g % 4)));
      check("rr_id", 32'(active_id_o), 32'(g % 4));
      check("rr_busy_ready", 32'(req_ready), 32'd0);
      tick();
      check("rr_run_tvalid", 32'(m_axis_tvalid), 32'd0);
      strobe_i = 1'b1;
      repeat (62) tick();
      check("rr_early_done", 32'(period_done_o), 32'd0);
      tick();
      strobe_i = 1'b0;
      check("rr_done", 32'(period_done_o), 32'd1);
      tick();
      check("rr_done_clr", 32'(period_done_o), 32'd0);
    end
    req_valid = '0;

    // Single request on requester 2, strobes spaced by idle cycles
    set_shift(2, 5);
    req_valid = 4'b0100;
    #1;
    check("single_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    #1;
    check("single_ready_clr", 32'(req_ready), 32'd0);
    check("single_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("single_tdata", 32'(m_axis_tdata), 32'd5);
    check("single_id", 32'(active_id_o), 32'd2);
    tick();
    check("single_tvalid_off", 32'(m_axis_tvalid), 32'd0);
    check("single_tdata_off", 32'(m_axis_tdata), 32'd0);
    check("single_busy", 32'(busy_o), 32'd1);
    for (int n = 0; n < 62; n++) begin
      strobe_i = 1'b1;
      tick();
      strobe_i = 1'b0;
      tick();
    end
    check("single_early_done", 32'(period_done_o), 32'd0);
    strobe_i = 1'b1;
    tick();
    strobe_i = 1'b0;
    check("single_done", 32'(period_done_o), 32'd1);
    tick();
    check("single_done_clr", 32'(period_done_o), 32'd0);
    check("single_idle", 32'(busy_o), 32'd0);
    check("single_id_hold", 32'(active_id_o), 32'd2);

    // Backpressure on requester 3 with the largest legal shift; strobes in IDLE/LOAD ignored
    m_axis_tready = 1'b0;
    set_shift(3, 62);
    req_valid = 4'b1000;
    strobe_i  = 1'b1;
    #1;
    check("bp_ready", 32'(req_ready), 32'b1000);
    tick();
    req_valid = '0;
    for (int c = 0; c < 10; c++) begin
      check("bp_tvalid", 32'(m_axis_tvalid), 32'd1);
      check("bp_tdata", 32'(m_axis_tdata), 32'd62);
      tick();
    end
    m_axis_tready = 1'b1;
    strobe_i      = 1'b0;
    #1;
    check("bp_hold", 32'(m_axis_tvalid), 32'd1);
    tick();
    check("bp_after", 32'(m_axis_tvalid), 32'd0);
    check("bp_busy", 32'(busy_o), 32'd1);
    strobe_i = 1'b1;
    repeat (62) tick();
    check("bp_early_done", 32'(period_done_o), 32'd0);
    tick();
    strobe_i = 1'b0;
    check("bp_done", 32'(period_done_o), 32'd1);
    tick();
    check("bp_idle", 32'(busy_o), 32'd0);

    // Out-of-range shift on requester 1, then requester 2 wins
    set_shift(1, 63);
    set_shift(2, 7);
    req_valid = 4'b0110;
    #1;
    check("oor_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b0100;
    #1;
    check("oor_err", 32'(err_o), 32'd1);
    check("oor_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("oor_busy", 32'(busy_o), 32'd0);
    check("oor_next_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    #1;
    check("oor_err_clr", 32'(err_o), 32'd0);
    check("oor2_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("oor2_tdata", 32'(m_axis_tdata), 32'd7);
    check("oor2_id", 32'(active_id_o), 32'd2);
    tick();
    strobe_i = 1'b1;
    repeat (30) tick();
    check("mid_busy", 32'(busy_o), 32'd1);

    // Asynchronous reset after 30 strobes
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    repeat (3) begin
      tick();
      check("rst_no_done", 32'(period_done_o), 32'd0);
    end
    strobe_i = 1'b0;
    set_shift(0, 20);
    req_valid = 4'b0001;
    #1;
    check("rst_ready_gated", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rel_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    #1;
    check("rel_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("rel_tdata", 32'(m_axis_tdata), 32'd20);
    check("rel_id", 32'(active_id_o), 32'd0);
    tick();
    check("rel_run_tvalid", 32'(m_axis_tvalid), 32'd0);
    strobe_i = 1'b1;
    repeat (62) tick();
    check("rel_early_done", 32'(period_done_o), 32'd0);
    check("rel_busy", 32'(busy_o), 32'd1);
    tick();
    strobe_i = 1'b0;
    check("rel_done", 32'(period_done_o), 32'd1);
    tick();
    check("rel_done_clr", 32'(period_done_o), 32'd0);
    check("rel_idle", 32'(busy_o), 32'd0);
    check("rel_err", 32'(err_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
